// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle between an operand producer and bin2bcd_seq.
// The master drives operands; the slave (converter) returns BCD digits.
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W  = 13,
    parameter int unsigned DIGITS = 4
);
    logic [BIN_W-1:0]    bin_i;
    logic                valid_i;
    logic                ready_o;
    logic [4*DIGITS-1:0] bcd_o;
    logic                valid_o;
    logic [DIGITS-1:0]   blank_o;

    modport master (
        output bin_i, valid_i,
        input  ready_o, bcd_o, valid_o, blank_o
    );

    modport slave (
        input  bin_i, valid_i,
        output ready_o, bcd_o, valid_o, blank_o
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per cycle.
// Feeds digits to the seven-segment counter/driver.
// Optional macro BIN2BCD_LZB_EN: registers a leading-zero blank mask with bcd_o;
// without it blank_o is tied to zero.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bin2bcd_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    operand;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_nxt;
    logic [4*DIGITS-1:0] bcd_r;
    logic                ready_r;
    logic                valid_r;
    logic                accept;
    logic                last_shift;

    assign accept     = bus.valid_i & ready_r;
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

    // One double-dabble step: add 3 to digits >= 5, then shift in the operand MSB.
    always_comb begin
        adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        scratch_nxt = {adj[4*DIGITS-2:0], operand[BIN_W-1]};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            operand <= '0;
            scratch <= '0;
            bcd_r   <= '0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (accept) begin
                        state   <= SHIFT;
                        ready_r <= 1'b0;
                        operand <= bus.bin_i;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    operand <= operand << 1;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        bcd_r   <= scratch_nxt;
                        valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_r;
    assign bus.valid_o = valid_r;
    assign bus.bcd_o   = bcd_r;

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0] blank_nxt;
    logic [DIGITS-1:0] blank_r;
    logic              zero_run;

    // A digit blanks when it and every more-significant digit are zero; units never blank.
    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int unsigned d = DIGITS - 1; d >= 1; d--) begin
            zero_run     = zero_run & (scratch_nxt[4*d +: 4] == 4'd0);
            blank_nxt[d] = zero_run;
        end
    end

    // Blank mask is captured alongside bcd_o on the final shift.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blank_r <= '0;
        end else if (last_shift) begin
            blank_r <= blank_nxt;
        end
    end

    assign bus.blank_o = blank_r;
`else
    assign bus.blank_o = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases, random operands,
// back-to-back streaming, mid-conversion reset and operand changes during SHIFT.
module tb_bin2bcd_seq;
    localparam int unsigned BIN_W  = 13;
    localparam int unsigned DIGITS = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division.
    function automatic logic [31:0] ref_bcd(input int unsigned n);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = n;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: digit d blanks when the value has fewer than d+1 decimal digits.
    function automatic logic [31:0] ref_blank(input int unsigned n);
        logic [31:0] r;
        int unsigned lim;
        r   = '0;
        lim = 1;
`ifdef BIN2BCD_LZB_EN
        for (int d = 1; d < DIGITS; d++) begin
            lim = lim * 10;
            if (n < lim) r[d] = 1'b1;
        end
`else
        lim = n;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.ready_o), 32'd1);
    endtask

    // Single-pulse conversion; inputs are scrambled while the converter is busy.
    task automatic convert(input int unsigned value);
        int early;
        logic [31:0] held;
        early = 0;
        wait_ready();
        bus.bin_i   = 13'(value);
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            if (k < 13) begin
                if (bus.valid_o !== 1'b0) early++;
                bus.bin_i   = 13'($urandom);
                bus.valid_i = 1'($urandom);
            end
        end
        check("valid_early", 32'(early), 32'd0);
        check("valid_strobe", 32'(bus.valid_o), 32'd1);
        check("bcd", 32'(bus.bcd_o), ref_bcd(value));
        check("blank", 32'(bus.blank_o), ref_blank(value));
        held = 32'(bus.bcd_o);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 32'(bus.valid_o), 32'd0);
        check("bcd_hold", 32'(bus.bcd_o), held);
        bus.valid_i = 1'b0;
    endtask

    initial begin
        int strobes;
        int ready_low;
        int first_k;
        int second_k;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.bin_i   = '0;
        bus.valid_i = 1'b0;

        #2;
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_bcd", 32'(bus.bcd_o), 32'd0);
        check("rst_blank", 32'(bus.blank_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(bus.ready_o), 32'd1);

        convert(0);
        convert(8191);
        convert(42);
        for (int i = 0; i < 20; i++) begin
            convert($urandom_range(0, 8191));
        end

        // Back-to-back with valid_i held high.
        wait_ready();
        bus.bin_i   = 13'd1234;
        bus.valid_i = 1'b1;
        strobes   = 0;
        ready_low = 0;
        first_k   = -1;
        second_k  = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) bus.bin_i = 13'd5678;
            if (k < 15 && bus.ready_o === 1'b0) ready_low++;
            if (bus.valid_o === 1'b1) begin
                strobes++;
                if (first_k < 0) begin
                    first_k = k;
                    check("b2b_bcd0", 32'(bus.bcd_o), 32'h1234);
                end else begin
                    second_k = k;
                    check("b2b_bcd1", 32'(bus.bcd_o), 32'h5678);
                end
            end
        end
        bus.valid_i = 1'b0;
        check("b2b_strobes", 32'(strobes), 32'd2);
        check("b2b_first", 32'(first_k), 32'd13);
        check("b2b_spacing", 32'(second_k - first_k), 32'd15);
        check("b2b_ready_low", 32'(ready_low), 32'd14);
        // Drain the third conversion that may have been accepted at the window end.
        for (int k = 0; k < 20; k++) @(posedge clk);

        // Reset in the middle of a conversion.
        wait_ready();
        bus.bin_i   = 13'($urandom_range(1, 8191));
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        for (int k = 0; k < 5; k++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.ready_o), 32'd0);
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        check("midrst_bcd", 32'(bus.bcd_o), 32'd0);
        check("midrst_blank", 32'(bus.blank_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o !== 1'b0) strobes++;
        end
        check("midrst_no_valid", 32'(strobes), 32'd0);
        convert(999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
